// File: rtl/ctrl_spi_slave.sv
// SPI mode-3 slave, fully oversampled in the clk domain.
// Received bytes go to a small FWFT RX FIFO; a one-byte holding register supplies replies.
module ctrl_spi_slave #(
  parameter int unsigned RX_FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_si,
  output logic       spi_so,
  output logic       spi_so_oe,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic       rx_rdy,
  input  logic [7:0] tx_dat,
  input  logic       tx_we,
  output logic       tx_full,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int unsigned Depth = 2 ** RX_FIFO_AW;
  localparam logic [RX_FIFO_AW:0] DepthCnt = (RX_FIFO_AW + 1)'(Depth);
  localparam logic [RX_FIFO_AW:0] CntOne = 1;
  localparam logic [RX_FIFO_AW-1:0] PtrOne = 1;

  logic [2:0] cs_sync_q, sck_sync_q;
  logic [1:0] si_sync_q, live_q;
  logic       armed_q, busy_q, so_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] so_shift_q, tx_hold_q;
  logic [6:0] rx_shift_q;
  logic       tx_full_q, ovf_q;
  logic [RX_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [RX_FIFO_AW:0]   cnt_q;
  logic [7:0] mem [Depth];

  logic cs_fall, cs_rise, sck_rise, sck_fall, si, act;
  logic load, push_req, push_ok, pop, fifo_full;

  always_comb begin
    // A select only counts once CS has been seen high after reset.
    cs_fall   = cs_sync_q[2] & ~cs_sync_q[1] & armed_q;
    cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
    sck_rise  = ~sck_sync_q[2] & sck_sync_q[1];
    sck_fall  = sck_sync_q[2] & ~sck_sync_q[1];
    si        = si_sync_q[1];
    act       = busy_q & ~cs_rise;
    load      = act & sck_fall & (bit_cnt_q == 3'd0);
    push_req  = act & sck_rise & (bit_cnt_q == 3'd7);
    fifo_full = (cnt_q == DepthCnt);
    pop       = rx_vld & rx_rdy;
    push_ok   = push_req & (~fifo_full | pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b111;
      si_sync_q  <= 2'b11;
      live_q     <= 2'b00;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      so_q       <= 1'b1;
      bit_cnt_q  <= 3'd0;
      so_shift_q <= 8'hFF;
      rx_shift_q <= 7'd0;
    end else begin
      cs_sync_q  <= {cs_sync_q[1:0], spi_cs_n};
      sck_sync_q <= {sck_sync_q[1:0], spi_clk};
      si_sync_q  <= {si_sync_q[0], spi_si};
      live_q     <= {live_q[0], 1'b1};
      if (live_q[1] && cs_sync_q[1]) armed_q <= 1'b1;
      if (cs_fall) begin
        busy_q     <= 1'b1;
        bit_cnt_q  <= 3'd0;
        so_shift_q <= 8'hFF;
        so_q       <= 1'b1;
      end else if (cs_rise) begin
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        so_q      <= 1'b1;
      end else if (busy_q) begin
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) so_shift_q <= tx_full_q ? tx_hold_q : 8'hFF;
          else                   so_shift_q <= {so_shift_q[6:0], 1'b1};
        end
        if (sck_rise) begin
          rx_shift_q <= {rx_shift_q[5:0], si};
          bit_cnt_q  <= bit_cnt_q + 3'd1;
        end
        so_q <= so_shift_q[7];
      end else begin
        so_q <= 1'b1;
      end
    end
  end

  // Byte-start load sees the pre-write holding state; a write on that cycle only lands if empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full_q <= 1'b0;
      tx_hold_q <= 8'hFF;
      ovf_q     <= 1'b0;
    end else begin
      if (load && tx_full_q) begin
        tx_full_q <= 1'b0;
      end else if (tx_we && !tx_full_q) begin
        tx_hold_q <= tx_dat;
        tx_full_q <= 1'b1;
      end
      if (push_req && !push_ok) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push_ok && !pop)      cnt_q <= cnt_q + CntOne;
      else if (!push_ok && pop) cnt_q <= cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {rx_shift_q, si};
  end

  assign rx_dat    = mem[rd_ptr_q];
  assign rx_vld    = (cnt_q != '0);
  assign spi_so    = so_q;
  assign spi_so_oe = busy_q;
  assign busy      = busy_q;
  assign tx_full   = tx_full_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ctrl_spi_slave.sv
// Directed bench for ctrl_spi_slave: bit-banged mode-3 master plus queue scoreboard
// for both the RX FIFO output and the MISO bytes seen by the master.
module tb_ctrl_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n, spi_cs_n, spi_clk, spi_si, spi_so, spi_so_oe;
  logic [7:0] rx_dat, tx_dat;
  logic       rx_vld, rx_rdy, tx_we, tx_full, ovf, ovf_clr, busy;

  int n_vec = 0;
  int n_bad = 0;
  int half = 8;
  int rdy_mode = 0;
  longint unsigned cyc = 0;
  longint unsigned pop_cycle = '1;
  logic [7:0] rx_exp_q[$], tx_exp_q[$], tx_obs_q[$];

  ctrl_spi_slave #(.RX_FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_si(spi_si),
    .spi_so(spi_so), .spi_so_oe(spi_so_oe), .rx_dat(rx_dat), .rx_vld(rx_vld),
    .rx_rdy(rx_rdy), .tx_dat(tx_dat), .tx_we(tx_we), .tx_full(tx_full), .ovf(ovf),
    .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: drives rx_rdy and scores every pop and every completed MISO byte.
  initial begin
    logic [7:0] obs;
    rx_rdy = 1'b0;
    forever begin
      @(negedge clk);
      rx_rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1) ||
               (cyc == pop_cycle);
      if (rx_vld && rx_rdy) begin
        if (rx_exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rx_pop: got %0h expected no data", rx_dat);
        end else chk("rx_dat", rx_dat, rx_exp_q.pop_front());
      end
      if (tx_obs_q.size() > 0) begin
        obs = tx_obs_q.pop_front();
        if (tx_exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL miso: got %0h expected nothing", obs);
        end else chk("miso", obs, tx_exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk); tx_dat = d; tx_we = 1'b1;
    @(negedge clk); tx_we = 1'b0;
  endtask

  task automatic frame_begin();
    @(negedge clk); spi_cs_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic frame_end();
    wait_clk(5); spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  // One byte (or nbits of one) as the master; starts and ends on a negedge with SCK high.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input logic [7:0] miso_exp,
                      input bit keep, input bit pop_on_push, input bit we_on_load,
                      input logic [7:0] we_dat);
    logic [7:0] got = 8'h00;
    if (nbits == 8) begin
      tx_exp_q.push_back(miso_exp);
      if (keep) rx_exp_q.push_back(mosi);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0; spi_si = mosi[7-i];
      for (int k = 0; k < half; k++) begin
        @(negedge clk);
        if (we_on_load && i == 0 && k == 1) begin tx_dat = we_dat; tx_we = 1'b1; end
        if (we_on_load && i == 0 && k == 2) tx_we = 1'b0;
      end
      got = {got[6:0], spi_so};
      spi_clk = 1'b1;
      if (pop_on_push && i == 7) pop_cycle = cyc + 2;
      wait_clk(half);
    end
    if (nbits == 8) tx_obs_q.push_back(got);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_so"}, spi_so, 1);
    chk({tag, "_oe"}, spi_so_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txfull"}, tx_full, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_rxvld"}, rx_vld, 0);
  endtask

  task automatic drain(input string tag);
    rdy_mode = 1;
    for (int i = 0; i < 200 && (rx_exp_q.size() != 0 || rx_vld); i++) wait_clk(1);
    rdy_mode = 0;
    wait_clk(2);
    chk({tag, "_rxvld"}, rx_vld, 0);
    chk({tag, "_rxleft"}, rx_exp_q.size(), 0);
    chk({tag, "_misoleft"}, tx_exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] hold_m, v, exp_so;
    bit full_m;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b1; spi_si = 1'b1;
    tx_we = 1'b0; tx_dat = 8'h00; ovf_clr = 1'b0;
    wait_clk(3);
    chk_idle("reset");
    rst_n = 1'b1;
    wait_clk(5);
    chk_idle("idle");

    // Reply then default
    tx_write(8'hA5);
    chk("a_txfull_set", tx_full, 1);
    frame_begin();
    chk("a_busy", busy, 1);
    chk("a_oe", spi_so_oe, 1);
    xfer(8'h3C, 8, 8'hA5, 1, 0, 0, 8'h00);
    chk("a_txfull_clr", tx_full, 0);
    xfer(8'h81, 8, 8'hFF, 1, 0, 0, 8'h00);
    frame_end();
    chk("a_busy_end", busy, 0);
    chk("a_rxvld", rx_vld, 1);
    drain("a");

    // Fill and overflow
    frame_begin();
    for (int b = 1; b <= 5; b++) xfer(8'(b), 8, 8'hFF, b < 5, 0, 0, 8'h00);
    frame_end();
    chk("b_ovf_set", ovf, 1);
    drain("b");
    chk("b_ovf_sticky", ovf, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("b_ovf_clr", ovf, 0);

    // Pop on the push cycle of the fifth byte
    frame_begin();
    for (int b = 0; b < 4; b++) xfer(8'h11 + 8'(b), 8, 8'hFF, 1, 0, 0, 8'h00);
    xfer(8'h15, 8, 8'hFF, 1, 1, 0, 8'h00);
    frame_end();
    chk("c_ovf", ovf, 0);
    drain("c");

    // Partial byte discarded
    frame_begin();
    xfer(8'hB0, 5, 8'hFF, 0, 0, 0, 8'h00);
    frame_end();
    chk("d_busy", busy, 0);
    chk("d_so", spi_so, 1);
    chk("d_oe", spi_so_oe, 0);
    chk("d_rxvld", rx_vld, 0);
    frame_begin();
    xfer(8'h55, 8, 8'hFF, 1, 0, 0, 8'h00);
    frame_end();
    drain("d");

    // Write collision with byte-start load, then write while full
    frame_begin();
    xfer(8'hC3, 8, 8'hFF, 1, 0, 1, 8'h12);
    chk("e_txfull_kept", tx_full, 1);
    tx_write(8'h34);
    chk("e_txfull_still", tx_full, 1);
    xfer(8'h5A, 8, 8'h12, 1, 0, 0, 8'h00);
    xfer(8'h96, 8, 8'hFF, 1, 0, 0, 8'h00);
    frame_end();
    drain("e");

    // Reset mid-byte with CS held low through release
    tx_write(8'h77);
    frame_begin();
    xfer(8'hE7, 3, 8'hFF, 0, 0, 0, 8'h00);
    @(negedge clk); rst_n = 1'b0; spi_clk = 1'b1; spi_si = 1'b1;
    wait_clk(1);
    chk_idle("f_rst");
    wait_clk(2); rst_n = 1'b1;
    wait_clk(10);
    chk("f_no_select", busy, 0);
    chk("f_no_oe", spi_so_oe, 0);
    spi_cs_n = 1'b1;
    wait_clk(8);
    frame_begin();
    xfer(8'h9E, 8, 8'hFF, 1, 0, 0, 8'h00);
    frame_end();
    drain("f");

    // Max-rate sweep with random replies and random pops
    half = 6; rdy_mode = 2; full_m = 1'b0; hold_m = 8'hFF;
    frame_begin();
    for (int b = 0; b < 16; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 255));
        tx_write(v);
        if (!full_m) begin hold_m = v; full_m = 1'b1; end
      end
      exp_so = full_m ? hold_m : 8'hFF;
      full_m = 1'b0;
      xfer(8'($urandom_range(0, 255)), 8, exp_so, 1, 0, 0, 8'h00);
    end
    frame_end();
    drain("g");
    chk("g_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
